// File: rtl/fetch_unit.sv
// Instruction fetch stage: one fetch per request over a valid/ready address channel and a
// valid/ready data channel. All outputs are registered.
module fetch_unit #(
    parameter int unsigned               ADDR_WIDTH = 32,
    parameter int unsigned               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_INST = 'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_fetch,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [ADDR_WIDTH-1:0] ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [DATA_WIDTH-1:0] ir_data,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  fetch_busy,
    output logic                  fetch_error
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                state_q;
    logic                  addr_valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  data_ready_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic                  inst_valid_q;
    logic                  busy_q;
    logic                  error_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            data_ready_q <= 1'b0;
            inst_q       <= RESET_INST;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle.
            inst_valid_q <= 1'b0;
            error_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (inst_fetch) begin
                        if (pc[1:0] == 2'b00) begin
                            addr_q       <= pc;
                            addr_valid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= StAddr;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                StAddr: begin
                    if (ir_addr_ready) begin
                        addr_valid_q <= 1'b0;
                        data_ready_q <= 1'b1;
                        state_q      <= StData;
                    end
                end
                StData: begin
                    if (ir_data_valid) begin
                        inst_q       <= ir_data;
                        inst_valid_q <= 1'b1;
                        data_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ir_addr_valid = addr_valid_q;
    assign ir_addr       = addr_q;
    assign ir_data_ready = data_ready_q;
    assign inst          = inst_q;
    assign inst_valid    = inst_valid_q;
    assign fetch_busy    = busy_q;
    assign fetch_error   = error_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-exact checks of the fetch handshakes.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_fetch;
    logic [31:0] pc;
    logic        ir_addr_valid;
    logic        ir_addr_ready;
    logic [31:0] ir_addr;
    logic        ir_data_valid;
    logic        ir_data_ready;
    logic [31:0] ir_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_busy;
    logic        fetch_error;

    int checks = 0;
    int errors = 0;
    int addr_hs = 0;
    int hs_base;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .inst_fetch    (inst_fetch),
        .pc            (pc),
        .ir_addr_valid (ir_addr_valid),
        .ir_addr_ready (ir_addr_ready),
        .ir_addr       (ir_addr),
        .ir_data_valid (ir_data_valid),
        .ir_data_ready (ir_data_ready),
        .ir_data       (ir_data),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .fetch_busy    (fetch_busy),
        .fetch_error   (fetch_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && ir_addr_valid && ir_addr_ready) addr_hs <= addr_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic av, input logic dr, input logic iv,
                           input logic bz, input logic er);
        chk({tag, ".addr_valid"}, 64'(ir_addr_valid), 64'(av));
        chk({tag, ".data_ready"}, 64'(ir_data_ready), 64'(dr));
        chk({tag, ".inst_valid"}, 64'(inst_valid), 64'(iv));
        chk({tag, ".busy"}, 64'(fetch_busy), 64'(bz));
        chk({tag, ".error"}, 64'(fetch_error), 64'(er));
    endtask

    initial begin
        rst = 1'b0; inst_fetch = 1'b0; pc = '0;
        ir_addr_ready = 1'b0; ir_data_valid = 1'b0; ir_data = '0;
        tick(); tick();
        chk_ctl("reset", 0, 0, 0, 0, 0);
        chk("reset.inst", 64'(inst), 64'h13);
        chk("reset.addr", 64'(ir_addr), 64'h0);
        rst = 1'b1;
        tick();

        // Zero-wait fetch
        pc = 32'h100; inst_fetch = 1'b1; ir_addr_ready = 1'b1;
        ir_data_valid = 1'b1; ir_data = 32'h00500093;
        tick();
        inst_fetch = 1'b0;
        chk_ctl("zw.t1", 1, 0, 0, 1, 0);
        chk("zw.t1.addr", 64'(ir_addr), 64'h100);
        tick();
        chk_ctl("zw.t2", 0, 1, 0, 1, 0);
        tick();
        chk_ctl("zw.t3", 0, 0, 1, 0, 0);
        chk("zw.t3.inst", 64'(inst), 64'h00500093);
        tick();
        chk_ctl("zw.t4", 0, 0, 0, 0, 0);

        // Address backpressure with pc changing during the wait
        ir_addr_ready = 1'b0; ir_data_valid = 1'b0;
        pc = 32'h100; inst_fetch = 1'b1;
        tick();
        inst_fetch = 1'b0; pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            chk_ctl("bp.wait", 1, 0, 0, 1, 0);
            chk("bp.wait.addr", 64'(ir_addr), 64'h100);
            if (i < 3) tick();
        end
        ir_addr_ready = 1'b1; ir_data_valid = 1'b1; ir_data = 32'h00A00113;
        tick();
        chk_ctl("bp.hs", 0, 1, 0, 1, 0);
        tick();
        chk_ctl("bp.done", 0, 0, 1, 0, 0);
        chk("bp.inst", 64'(inst), 64'h00A00113);

        // Data delay plus a spurious request mid-DATA
        ir_data_valid = 1'b0; pc = 32'h300; inst_fetch = 1'b1;
        hs_base = addr_hs;
        tick();
        inst_fetch = 1'b0;
        chk("dd.addr", 64'(ir_addr), 64'h300);
        tick();
        for (int i = 0; i < 5; i++) begin
            inst_fetch = (i == 2);
            chk_ctl("dd.wait", 0, 1, 0, 1, 0);
            tick();
        end
        inst_fetch = 1'b0;
        chk_ctl("dd.wait_end", 0, 1, 0, 1, 0);
        ir_data_valid = 1'b1; ir_data = 32'h40000033;
        tick();
        chk_ctl("dd.done", 0, 0, 1, 0, 0);
        chk("dd.inst", 64'(inst), 64'h40000033);
        tick();
        chk_ctl("dd.after", 0, 0, 0, 0, 0);
        chk("dd.addr_hs", 64'(addr_hs - hs_base), 64'd1);

        // Misaligned pc rejected
        pc = 32'h102; inst_fetch = 1'b1;
        tick();
        inst_fetch = 1'b0;
        chk_ctl("mis.t1", 0, 0, 0, 0, 1);
        chk("mis.inst", 64'(inst), 64'h40000033);
        tick();
        chk_ctl("mis.t2", 0, 0, 0, 0, 0);

        // Reset while waiting for data
        ir_data_valid = 1'b0; pc = 32'h400; inst_fetch = 1'b1;
        tick();
        inst_fetch = 1'b0;
        tick();
        chk_ctl("rst.pre", 0, 1, 0, 1, 0);
        rst = 1'b0; ir_data_valid = 1'b1; ir_data = 32'hDEADBEEF;
        tick();
        rst = 1'b1;
        chk_ctl("rst.post", 0, 0, 0, 0, 0);
        chk("rst.inst", 64'(inst), 64'h13);
        tick();
        chk_ctl("rst.idle", 0, 0, 0, 0, 0);

        // Fresh fetch after reset, then back-to-back request in the inst_valid cycle
        pc = 32'h500; inst_fetch = 1'b1; ir_data = 32'h00100193;
        tick();
        inst_fetch = 1'b0;
        chk("fresh.addr", 64'(ir_addr), 64'h500);
        tick(); tick();
        chk_ctl("fresh.done", 0, 0, 1, 0, 0);
        chk("fresh.inst", 64'(inst), 64'h00100193);
        pc = 32'h104; inst_fetch = 1'b1; ir_data = 32'h00200213;
        tick();
        inst_fetch = 1'b0;
        chk_ctl("b2b.t1", 1, 0, 0, 1, 0);
        chk("b2b.addr", 64'(ir_addr), 64'h104);
        tick(); tick();
        chk_ctl("b2b.done", 0, 0, 1, 0, 0);
        chk("b2b.inst", 64'(inst), 64'h00200213);

        // All-high aligned address passes through unchanged
        pc = 32'hFFFFFFFC; inst_fetch = 1'b1; ir_data = 32'h00000073;
        tick();
        inst_fetch = 1'b0;
        chk("wrap.addr", 64'(ir_addr), 64'hFFFFFFFC);
        tick(); tick();
        chk("wrap.inst", 64'(inst), 64'h00000073);
        chk_ctl("wrap.done", 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
